decimal_converter: RTL and testbench
====================================

# decimal_converter

Converts an N-bit unsigned binary value into packed BCD digits by repeatedly dividing by ten through an external Divider instance. It sits directly upstream of the Divider: it drives the divider's start, dividend and divisor, and consumes its finished, quotient, remainder and undefined outputs. Typical use is the numeric display and print path, which needs decimal digits from a binary result.

## Interface
- N, default 8: operand width; must match the attached Divider's N; N >= 4 so that 10 is representable.
- DIGITS, default 3: BCD digits produced; must satisfy 10^DIGITS > 2^N - 1.
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  request conversion of i_value; sampled only in IDLE.
- i_value  in  N  unsigned binary input, latched on accepted start.
- o_busy  out  1  high in ISSUE, WAIT and DONE.
- o_finished  out  1  one-cycle pulse when conversion completes.
- o_digits  out  4*DIGITS  BCD result; digit 0 is in bits [3:0]; registered and held.
- o_error  out  1  set when the divider reports undefined; cleared on next accepted start.
- o_div_start  out  1  one-cycle start pulse to the divider.
- o_div_dividend  out  N  dividend to the divider; equals the work register.
- o_div_divisor  out  N  constant 10.
- i_div_finished  in  1  divider completion.
- i_div_quotient  in  N  divider quotient.
- i_div_remainder  in  N  divider remainder; only bits [3:0] are used.
- i_div_undefined  in  1  divider divide-by-zero flag.

## Operation
- State machine states: IDLE, ISSUE, WAIT, DONE.
- IDLE, when i_start = 1:
  - work <= i_value; idx <= 0; digit scratch <= 0; o_error <= 0.
  - Next state: ISSUE.
- ISSUE: o_div_start = 1 for exactly this cycle. Next state: WAIT.
- WAIT:
  - While i_div_finished = 0, stay in WAIT.
  - On i_div_finished = 1 with i_div_undefined = 1: o_error <= 1; next state DONE; o_digits is not updated.
  - Otherwise: scratch[idx] <= i_div_remainder[3:0]; work <= i_div_quotient.
  - If i_div_quotient == 0 or idx == DIGITS-1: next state DONE. Else: idx <= idx + 1; next state ISSUE.
- DONE:
  - o_finished = 1; o_digits <= scratch, unless an error occurred.
  - Next state: IDLE.
- Early exit: digits above the last computed digit remain 0 in the scratch register.
- Value 0 costs one division and yields all-zero digits.
- i_start outside IDLE is ignored. There is no queueing.
- Divider contract: the divider deasserts finished no later than the cycle after it samples start, so WAIT never consumes a stale finished.

## Timing
- Let L = the divider's cycles from the start sample to finished = 1.
- Let k = the number of divisions = max(1, decimal length of value), which is at most DIGITS.
- The i_start sample is cycle 0. The first ISSUE is cycle 1.
- Each division occupies L+1 cycles (ISSUE through the WAIT that sees finished).
- o_finished is high on cycle k*(L+1)+1. The converter accepts a new start on the following cycle.
- Reset values: state IDLE, o_busy 0, o_finished 0, o_digits 0, o_error 0, o_div_start 0, work 0.
- Reset in any state, including mid-WAIT, returns to IDLE next cycle with the reset values above.
- The divider shares i_reset, so a pending division is discarded.
- i_div_finished outside WAIT is ignored.

## Configuration
- DECIMAL_CONVERTER_BLANK_EN defined:
  - In DONE, every digit above the most significant nonzero digit is written as 4'hF (blank).
  - Digit 0 is never blanked, so value 0 gives F…F0.
- Undefined: all unused upper digits are 0.
- The macro does not change latency.

## Test plan
Benches use N=8, DIGITS=3 and a real Divider.
- Value 255: three start pulses with dividends 255, 25, 2, divisor 10 -> o_digits 0x255, o_finished on cycle 3(L+1)+1.
- Value 0: one division -> o_digits 0x000, or 0xFF0 with BLANK_EN; o_finished on cycle L+2.
- Value 7: one division -> 0x007, or 0xFF7 with BLANK_EN.
- Value 100: quotients 10, 1, 0 -> 0x100 with or without BLANK_EN. Value 40: 0x040, or 0xF40.
- i_start pulsed during WAIT -> ignored. Assert i_reset mid-WAIT -> next cycle all outputs 0 and IDLE; a new start with 42 -> 0x042.
- Stub divider asserts i_div_undefined with finished -> o_error 1, o_finished pulses, o_digits keeps previous value; next start clears o_error.

Source files
------------

// File: rtl/decimal_converter_if.sv
// Converter request/result signals and the divider-facing handshake in one bundle.
// slave = converter view, master = the client/divider environment view.
interface decimal_converter_if #(
   parameter int N      = 8,
   parameter int DIGITS = 3
);
   logic                  i_start;
   logic [N-1:0]          i_value;
   logic                  o_busy;
   logic                  o_finished;
   logic [4*DIGITS-1:0]   o_digits;
   logic                  o_error;
   logic                  o_div_start;
   logic [N-1:0]          o_div_dividend;
   logic [N-1:0]          o_div_divisor;
   logic                  i_div_finished;
   logic [N-1:0]          i_div_quotient;
   logic [N-1:0]          i_div_remainder;
   logic                  i_div_undefined;

   modport slave (
      input  i_start, i_value, i_div_finished, i_div_quotient, i_div_remainder, i_div_undefined,
      output o_busy, o_finished, o_digits, o_error, o_div_start, o_div_dividend, o_div_divisor
   );

   modport master (
      output i_start, i_value, i_div_finished, i_div_quotient, i_div_remainder, i_div_undefined,
      input  o_busy, o_finished, o_digits, o_error, o_div_start, o_div_dividend, o_div_divisor
   );
endinterface

// File: rtl/decimal_converter.sv
// Binary-to-BCD converter that repeatedly divides by ten through an external divider.
// Optional DECIMAL_CONVERTER_BLANK_EN: leading zero digits (except digit 0) become 4'hF.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for i_start; latches i_value into the work register
// S_ISSUE | o_div_start high for this single cycle
// S_WAIT  | waiting for the divider; stores one digit per completion
// S_DONE  | o_finished pulse; o_digits already holds the result
module decimal_converter #(
   parameter int N      = 8,
   parameter int DIGITS = 3
) (
   input  logic                i_clock,
   input  logic                i_reset,
   decimal_converter_if.slave  bus
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                state;
   logic [N-1:0]          work;
   logic [IDX_W-1:0]      idx;
   logic [4*DIGITS-1:0]   scratch;
   logic [4*DIGITS-1:0]   scratch_nxt;
   logic [4*DIGITS-1:0]   digits_nxt;
   logic                  busy;
   logic                  finished;
   logic [4*DIGITS-1:0]   digits;
   logic                  error;
   logic                  div_start;
   logic                  unused_rem_hi;

   assign unused_rem_hi = ^bus.i_div_remainder[N-1:4];

   always_comb begin
      scratch_nxt = scratch;
      scratch_nxt[4*idx +: 4] = bus.i_div_remainder[3:0];
   end

`ifdef DECIMAL_CONVERTER_BLANK_EN
   // Scan from the top: digits above the first nonzero one are blanked.
   always_comb begin
      logic seen;
      seen       = 1'b0;
      digits_nxt = scratch_nxt;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (scratch_nxt[4*i +: 4] != 4'd0) seen = 1'b1;
         if (!seen) digits_nxt[4*i +: 4] = 4'hF;
      end
   end
`else
   assign digits_nxt = scratch_nxt;
`endif

   // o_digits is written on entry to S_DONE so it is valid alongside o_finished.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state     <= S_IDLE;
         work      <= '0;
         idx       <= '0;
         scratch   <= '0;
         busy      <= 1'b0;
         finished  <= 1'b0;
         digits    <= '0;
         error     <= 1'b0;
         div_start <= 1'b0;
      end else begin
         div_start <= 1'b0;
         finished  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  work      <= bus.i_value;
                  idx       <= '0;
                  scratch   <= '0;
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  div_start <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (bus.i_div_finished) begin
                  if (bus.i_div_undefined) begin
                     error    <= 1'b1;
                     finished <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     scratch <= scratch_nxt;
                     work    <= bus.i_div_quotient;
                     if (bus.i_div_quotient == '0 || idx == LAST_IDX) begin
                        digits   <= digits_nxt;
                        finished <= 1'b1;
                        state    <= S_DONE;
                     end else begin
                        idx       <= idx + 1'b1;
                        div_start <= 1'b1;
                        state     <= S_ISSUE;
                     end
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_busy         = busy;
   assign bus.o_finished     = finished;
   assign bus.o_digits       = digits;
   assign bus.o_error        = error;
   assign bus.o_div_start    = div_start;
   assign bus.o_div_dividend = work;
   assign bus.o_div_divisor  = N'(10);
endmodule

// File: tb/tb_decimal_converter.sv
// Directed bench for decimal_converter with a behavioural fixed-latency divider.
module tb_decimal_converter;
   localparam int N      = 8;
   localparam int DIGITS = 3;
   localparam int LAT    = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic force_undef = 1'b0;
   logic [N-1:0] div_log[$];

   decimal_converter_if #(.N(N), .DIGITS(DIGITS)) bus ();

   decimal_converter #(.N(N), .DIGITS(DIGITS)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Divider: samples start, finished rises LAT cycles after the start sample.
   logic [N-1:0] dd, ds;
   int           cnt;
   always @(posedge clk) begin
      if (rst) begin
         bus.i_div_finished  <= 1'b0;
         bus.i_div_quotient  <= '0;
         bus.i_div_remainder <= '0;
         bus.i_div_undefined <= 1'b0;
         cnt                 <= 0;
      end else if (bus.o_div_start) begin
         dd                 <= bus.o_div_dividend;
         ds                 <= bus.o_div_divisor;
         bus.i_div_finished <= 1'b0;
         cnt                <= LAT - 1;
      end else if (cnt > 1) begin
         cnt <= cnt - 1;
      end else if (cnt == 1) begin
         cnt                <= 0;
         bus.i_div_finished <= 1'b1;
         if (force_undef || ds == 0) begin
            bus.i_div_undefined <= 1'b1;
            bus.i_div_quotient  <= '1;
            bus.i_div_remainder <= '1;
         end else begin
            bus.i_div_undefined <= 1'b0;
            bus.i_div_quotient  <= dd / ds;
            bus.i_div_remainder <= dd % ds;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.o_div_start) div_log.push_back(bus.o_div_dividend);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sel(input logic [31:0] plain, input logic [31:0] blank);
`ifdef DECIMAL_CONVERTER_BLANK_EN
      return blank;
`else
      return plain;
`endif
   endfunction

   task automatic start_pulse(input logic [N-1:0] v);
      @(negedge clk);
      bus.i_start = 1'b1;
      bus.i_value = v;
      @(negedge clk);
      bus.i_start = 1'b0;
   endtask

   // Called at the negedge of cycle 1; returns the cycle on which o_finished is seen.
   task automatic wait_done(input int inj_at, input logic [N-1:0] inj_val, output int cyc);
      cyc = 1;
      while (!bus.o_finished && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == inj_at) begin
            bus.i_start = 1'b1;
            bus.i_value = inj_val;
         end else begin
            bus.i_start = 1'b0;
         end
      end
      bus.i_start = 1'b0;
      chk("finished_seen", 32'(bus.o_finished), 32'd1);
   endtask

   task automatic conv(input string tag, input logic [N-1:0] v, input logic [31:0] exp_digits,
                       input int k, input int inj_at);
      int cyc;
      div_log.delete();
      start_pulse(v);
      chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      wait_done(inj_at, 8'd7, cyc);
      chk({tag, "_cycle"}, 32'(cyc), 32'(k * (LAT + 1) + 1));
      chk({tag, "_digits"}, 32'(bus.o_digits), exp_digits);
      chk({tag, "_error"}, 32'(bus.o_error), 32'd0);
      chk({tag, "_ndiv"}, 32'(div_log.size()), 32'(k));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(bus.o_finished), 32'd0);
      chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      int cyc;
      bus.i_start = 1'b0;
      bus.i_value = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_fin", 32'(bus.o_finished), 32'd0);
      chk("rst_digits", 32'(bus.o_digits), 32'd0);
      chk("rst_err", 32'(bus.o_error), 32'd0);
      chk("rst_dstart", 32'(bus.o_div_start), 32'd0);
      chk("rst_work", 32'(bus.o_div_dividend), 32'd0);
      chk("divisor", 32'(bus.o_div_divisor), 32'd10);
      rst = 1'b0;

      conv("v255", 8'd255, 32'h255, 3, 0);
      chk("v255_dd0", 32'(div_log[0]), 32'd255);
      chk("v255_dd1", 32'(div_log[1]), 32'd25);
      chk("v255_dd2", 32'(div_log[2]), 32'd2);
      conv("v0", 8'd0, sel(32'h000, 32'hFF0), 1, 0);
      conv("v7", 8'd7, sel(32'h007, 32'hFF7), 1, 0);
      conv("v100", 8'd100, 32'h100, 3, 0);
      chk("v100_dd1", 32'(div_log[1]), 32'd10);
      chk("v100_dd2", 32'(div_log[2]), 32'd1);
      conv("v40", 8'd40, sel(32'h040, 32'hF40), 2, 0);
      conv("ign", 8'd255, 32'h255, 3, 3);
      chk("ign_dd0", 32'(div_log[0]), 32'd255);

      // reset in the middle of WAIT
      start_pulse(8'd200);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_busy", 32'(bus.o_busy), 32'd0);
      chk("mrst_fin", 32'(bus.o_finished), 32'd0);
      chk("mrst_digits", 32'(bus.o_digits), 32'd0);
      chk("mrst_dstart", 32'(bus.o_div_start), 32'd0);
      chk("mrst_work", 32'(bus.o_div_dividend), 32'd0);
      conv("v42", 8'd42, sel(32'h042, 32'hF42), 2, 0);

      // divider reports undefined on the first division
      force_undef = 1'b1;
      start_pulse(8'd99);
      wait_done(0, 8'd0, cyc);
      chk("undef_cycle", 32'(cyc), 32'(LAT + 2));
      chk("undef_err", 32'(bus.o_error), 32'd1);
      chk("undef_digits", 32'(bus.o_digits), sel(32'h042, 32'hF42));
      @(negedge clk);
      chk("undef_pulse", 32'(bus.o_finished), 32'd0);
      force_undef = 1'b0;
      start_pulse(8'd5);
      chk("clr_err", 32'(bus.o_error), 32'd0);
      wait_done(0, 8'd0, cyc);
      chk("v5_digits", 32'(bus.o_digits), sel(32'h005, 32'hFF5));
      chk("v5_err", 32'(bus.o_error), 32'd0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
